// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default multi-cycle latencies and register address width.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MUL_CYCLES_DEF  = 3;
    localparam int RSQR_CYCLES_DEF = 8;
    localparam int REG_ADDR_W      = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of decode/execute hazard inputs and pipeline stall/flush controls
// exchanged between the core datapath and the hazard controller.
interface pipeline_hazard_ctrl_if;
    import hazard_pkg::*;

    // Hazard sources from ID and ID/EX
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  ex_is_mul;
    logic                  ex_is_rsqr;
    logic                  ex_redirect;

    // Pipeline register controls and status
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_stall;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mc_busy;
    logic                  mc_done;
    logic [15:0]           stall_count;

    // Datapath side: supplies hazard sources, consumes controls
    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_rd_addr, ex_mem_read, ex_is_mul, ex_is_rsqr, ex_redirect,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_flush, mc_busy, mc_done, stall_count
    );

    // Controller side
    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_rd_addr, ex_mem_read, ex_is_mul, ex_is_rsqr, ex_redirect,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_flush, mc_busy, mc_done, stall_count
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare: the instruction in ID reads a register
// that the load currently in EX has not yet fetched from memory.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  mem_read,
    output logic                  hazard
);

    // x0 is never a real dependency, so a load to x0 never stalls
    assign hazard = mem_read && (rd_addr != '0) &&
                    ((uses_rs1 && (rs1_addr == rd_addr)) ||
                     (uses_rs2 && (rs2_addr == rd_addr)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: holds multi-cycle execute ops
// in EX for their full latency, bubbles load-use hazards and squashes
// wrong-path instructions on EX redirects.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES  = MUL_CYCLES_DEF,
    parameter int RSQR_CYCLES = RSQR_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [CNT_W-1:0] MUL_N  = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] RSQR_N = CNT_W'(RSQR_CYCLES);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] op_len;
    logic [15:0]      stall_cnt;
    logic             mc_op;
    logic             lu_hazard;
    logic             busy;

    load_use_detect u_lu (
        .rs1_addr (hz.id_rs1_addr),
        .rs2_addr (hz.id_rs2_addr),
        .uses_rs1 (hz.id_uses_rs1),
        .uses_rs2 (hz.id_uses_rs2),
        .rd_addr  (hz.ex_rd_addr),
        .mem_read (hz.ex_mem_read),
        .hazard   (lu_hazard)
    );

    // Mul latency wins if both op flags are (illegally) raised together
    assign mc_op  = hz.ex_is_mul || hz.ex_is_rsqr;
    assign op_len = hz.ex_is_mul ? MUL_N : RSQR_N;

    // Next-state and pipeline control decode, priority reset > busy > redirect > load-use
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nx        = state;
        cnt_nx          = cnt;
        busy            = 1'b0;
        hz.mc_done      = 1'b0;
        hz.pc_stall     = 1'b0;
        hz.if_id_stall  = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_stall  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (mc_op) begin
                        if (op_len == CNT_W'(1)) begin
                            hz.mc_done = 1'b1;
                        end else begin
                            busy     = 1'b1;
                            cnt_nx   = op_len - CNT_W'(2);
                            state_nx = RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        busy   = 1'b1;
                        cnt_nx = cnt - CNT_W'(1);
                    end else begin
                        hz.mc_done = 1'b1;
                        state_nx   = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase

            // Flushes are suppressed while busy: they would kill the held op
            if (busy) begin
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_stall  = 1'b1;
                hz.ex_mem_flush = 1'b1;
            end else if (hz.ex_redirect) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (lu_hazard) begin
                hz.pc_stall    = 1'b1;
                hz.if_id_stall = 1'b1;
                hz.id_ex_flush = 1'b1;
            end
        end
    end

    assign hz.mc_busy     = busy;
    assign hz.stall_count = stall_cnt;

    // State, occupancy counter and saturating stall counter
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (hz.pc_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Both multi-cycle flags in EX at once is a decoder bug
    a_one_mc_op : assert property (@(posedge clk) disable iff (reset)
        !(hz.ex_is_mul && hz.ex_is_rsqr));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level occupancy model
// checked on every falling edge, plus directed hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_N  = 3;
    localparam int RSQR_N = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MUL_CYCLES  (MUL_N),
        .RSQR_CYCLES (RSQR_N),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, mc_busy, mc_done}
    function automatic logic [7:0] ctrl_vec();
        return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
                hz.id_ex_flush, hz.ex_mem_flush, hz.mc_busy, hz.mc_done};
    endfunction

    // ---------------- reference model ----------------
    // occ: cycles the current multi-cycle op has already spent in EX (0 = none)
    int occ     = 0;
    int total   = 0;
    int m_count = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        bit active, m_busy, m_done, lu;
        int occ_now, tot_now;
        e = '0;
        if (reset) begin
            check("ctrl", 32'(ctrl_vec()), 32'(e));
            check("stall_count", 32'(hz.stall_count), 32'(m_count));
            occ     = 0;
            m_count = 0;
        end else begin
            active  = (occ > 0) || hz.ex_is_mul || hz.ex_is_rsqr;
            tot_now = (occ > 0) ? total : (hz.ex_is_mul ? MUL_N : RSQR_N);
            occ_now = occ + 1;
            m_busy  = active && (occ_now < tot_now);
            m_done  = active && (occ_now == tot_now);
            lu = hz.ex_mem_read && (hz.ex_rd_addr != 0) &&
                 ((hz.id_uses_rs1 && hz.id_rs1_addr == hz.ex_rd_addr) ||
                  (hz.id_uses_rs2 && hz.id_rs2_addr == hz.ex_rd_addr));
            if (m_busy)              e = 8'b1101_0110;
            else if (hz.ex_redirect) e = 8'b0010_1000;
            else if (lu)             e = 8'b1100_1000;
            e[0] = m_done;
            check("ctrl", 32'(ctrl_vec()), 32'(e));
            check("stall_count", 32'(hz.stall_count), 32'(m_count));
            occ   = m_busy ? occ_now : 0;
            total = tot_now;
            if (e[7] && m_count < 65535) m_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        hz.id_rs1_addr = '0;
        hz.id_rs2_addr = '0;
        hz.id_uses_rs1 = 1'b0;
        hz.id_uses_rs2 = 1'b0;
        hz.ex_rd_addr  = '0;
        hz.ex_mem_read = 1'b0;
        hz.ex_is_mul   = 1'b0;
        hz.ex_is_rsqr  = 1'b0;
        hz.ex_redirect = 1'b0;
    endtask

    // Load to rd in EX, ID instruction reads rd through rs2
    task automatic set_lu(input logic [4:0] rd);
        hz.ex_mem_read = 1'b1;
        hz.ex_rd_addr  = rd;
        hz.id_rs2_addr = rd;
        hz.id_uses_rs2 = 1'b1;
        hz.id_rs1_addr = 5'd1;
        hz.id_uses_rs1 = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clr();
        reset = 1'b1;
        step(2);
        #1;
        check("reset_ctrl", 32'(ctrl_vec()), 32'h0);
        check("reset_count", 32'(hz.stall_count), 32'd0);
        reset = 1'b0;
        step();

        // load-use: lw x5 in EX, ID reads x5 via rs2
        set_lu(5'd5);
        #1;
        check("lu_ctrl", 32'(ctrl_vec()), 32'b1100_1000);
        step();
        clr();
        #1;
        check("lu_after_ctrl", 32'(ctrl_vec()), 32'h0);
        check("lu_count", 32'(hz.stall_count), 32'd1);
        step();

        // load to x0 never stalls
        set_lu(5'd0);
        #1;
        check("lu_x0_ctrl", 32'(ctrl_vec()), 32'h0);
        step();
        clr();

        // mul, 3 cycles in EX
        hz.ex_is_mul = 1'b1;
        #1;
        check("mul_t0", 32'(ctrl_vec()), 32'b1101_0110);
        step();
        check("mul_t1", 32'(ctrl_vec()), 32'b1101_0110);
        step();
        check("mul_t2", 32'(ctrl_vec()), 32'b0000_0001);
        step();
        clr();
        #1;
        check("mul_t3", 32'(ctrl_vec()), 32'h0);
        check("mul_count", 32'(hz.stall_count), 32'd3);
        step();

        // rsqr, 8 cycles, redirect + load-use injected mid-op must be ignored
        hz.ex_is_rsqr = 1'b1;
        for (int i = 0; i < RSQR_N; i++) begin
            hz.ex_redirect = (i == 3);
            if (i == 3) set_lu(5'd7);
            else begin
                hz.ex_mem_read = 1'b0;
                hz.id_uses_rs1 = 1'b0;
                hz.id_uses_rs2 = 1'b0;
            end
            #1;
            check("rsqr_if_id_flush", 32'(hz.if_id_flush), 32'd0);
            check("rsqr_id_ex_flush", 32'(hz.id_ex_flush), 32'd0);
            check("rsqr_busy", 32'(hz.mc_busy), 32'(i < RSQR_N - 1));
            check("rsqr_done", 32'(hz.mc_done), 32'(i == RSQR_N - 1));
            step();
        end
        clr();
        #1;
        check("rsqr_count", 32'(hz.stall_count), 32'd10);

        // redirect wins over load-use
        hz.ex_redirect = 1'b1;
        set_lu(5'd9);
        #1;
        check("redir_ctrl", 32'(ctrl_vec()), 32'b0010_1000);
        step();
        clr();

        // reset in the middle of a mul, then a fresh full-length mul
        hz.ex_is_mul = 1'b1;
        #1;
        step();
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'(ctrl_vec()), 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("rst_mid_count", 32'(hz.stall_count), 32'd0);
        check("fresh_t0", 32'(ctrl_vec()), 32'b1101_0110);
        step();
        check("fresh_t1", 32'(ctrl_vec()), 32'b1101_0110);
        step();
        check("fresh_t2", 32'(ctrl_vec()), 32'b0000_0001);
        step();
        clr();
        #1;
        check("fresh_count", 32'(hz.stall_count), 32'd2);
        step();

        // load-use during busy is ignored, but evaluated in the mc_done cycle
        hz.ex_is_mul = 1'b1;
        step();
        set_lu(5'd4);
        #1;
        check("mul_lu_busy", 32'(ctrl_vec()), 32'b1101_0110);
        step();
        check("mul_lu_done", 32'(ctrl_vec()), 32'b1100_1001);
        step();
        clr();
        #1;
        check("mul_lu_count", 32'(hz.stall_count), 32'd5);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
